// File: rtl/fifo_mem_mch_pkg.sv
// Shared helpers for the multi-channel FIFO storage block: width derivation,
// Gray conversion and per-channel slice positions on packed pointer buses.
package fifo_mem_pkg;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int ch_w(input int nch);
    return (nch < 2) ? 1 : $clog2(nch);
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Channel c owns bits [c*(aw+1) +: aw+1] of every packed pointer bus.
  function automatic int ptr_lsb(input int c, input int aw);
    return c * (aw + 1);
  endfunction

endpackage

// File: rtl/fifo_mem_mch_if.sv
// Write/read bundle of fifo_mem_mch; master drives requests, slave is the storage block.
interface fifo_mem_mch_if
  import fifo_mem_pkg::*;
#(
  parameter int DATA  = 16,
  parameter int DEPTH = 8,
  parameter int NCH   = 4
);
  localparam int AW = addr_w(DEPTH);
  localparam int CW = ch_w(NCH);
  localparam int PW = AW + 1;

  logic                winc;
  logic [CW-1:0]       wch;
  logic [DATA-1:0]     wdata;
  logic [NCH*PW-1:0]   wq2_rptr;
  logic [NCH-1:0]      ovf_clr;
  logic [CW-1:0]       rch;
  logic [AW-1:0]       raddr;
  logic [DATA-1:0]     rdata;
  logic [NCH*PW-1:0]   wptr_gray;
  logic [NCH-1:0]      wfull;
  logic [NCH-1:0]      wovf;

  modport master (
    output winc, wch, wdata, wq2_rptr, ovf_clr, rch, raddr,
    input  rdata, wptr_gray, wfull, wovf
  );

  modport slave (
    input  winc, wch, wdata, wq2_rptr, ovf_clr, rch, raddr,
    output rdata, wptr_gray, wfull, wovf
  );

endinterface

// File: rtl/fifo_mem_mch_wptr_full.sv
// Write-side state of one channel: binary/Gray write pointer, registered full
// flag and sticky overflow flag.
module fifo_wptr_full
  import fifo_mem_pkg::*;
#(
  parameter int AW = 3
) (
  input  logic          wclk,
  input  logic          wrst_n,
  input  logic          winc,
  input  logic [AW:0]   rq2_gray,
  input  logic          ovf_clr,
  output logic          accept,
  output logic [AW-1:0] waddr,
  output logic [AW:0]   gray,
  output logic          full,
  output logic          ovf
);

  // Full when the next write pointer equals the read pointer with its top two Gray bits inverted.
  localparam logic [AW:0] FULL_MASK = (AW + 1)'(3 << (AW - 1));

  logic [AW:0] bin_q, bin_d;
  logic [AW:0] gray_q, gray_d;
  logic        full_q, full_d;
  logic        ovf_q, ovf_d;

  always_comb begin
    accept = winc & ~full_q;
    bin_d  = bin_q + (AW + 1)'(accept);
    gray_d = (AW + 1)'(bin2gray(32'(bin_d)));
    full_d = (gray_d == (rq2_gray ^ FULL_MASK));
    // A write to a full channel in the same cycle as a clear keeps the flag set.
    ovf_d  = (ovf_q & ~ovf_clr) | (winc & full_q);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      full_q <= full_d;
      ovf_q  <= ovf_d;
    end
  end

  assign waddr = bin_q[AW-1:0];
  assign gray  = gray_q;
  assign full  = full_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/fifo_mem_mch.sv
// Multi-channel FIFO storage: NCH logical FIFOs of DEPTH words in one register
// array, write-domain pointers per channel, combinational read by channel/address.
module fifo_mem_mch
  import fifo_mem_pkg::*;
#(
  parameter int DATA  = 16,
  parameter int DEPTH = 8,
  parameter int NCH   = 4
) (
  input logic           wclk,
  input logic           wrst_n,
  fifo_mem_mch_if.slave bus
);

  localparam int AW  = addr_w(DEPTH);
  localparam int CW  = ch_w(NCH);
  localparam int PW  = AW + 1;
  localparam int MW  = NCH * DEPTH;
  localparam int MIW = $clog2(MW);

  logic [DATA-1:0]   mem_q [MW];
  logic [DATA-1:0]   mem_d [MW];
  logic [NCH-1:0]    ch_accept;
  logic [AW-1:0]     ch_waddr [NCH];
  logic [NCH*PW-1:0] gray_all;
  logic [NCH-1:0]    full_all;
  logic [NCH-1:0]    ovf_all;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    fifo_wptr_full #(.AW(AW)) u_wptr (
      .wclk     (wclk),
      .wrst_n   (wrst_n),
      .winc     (bus.winc && (bus.wch == CW'(c))),
      .rq2_gray (bus.wq2_rptr[ptr_lsb(c, AW) +: PW]),
      .ovf_clr  (bus.ovf_clr[c]),
      .accept   (ch_accept[c]),
      .waddr    (ch_waddr[c]),
      .gray     (gray_all[ptr_lsb(c, AW) +: PW]),
      .full     (full_all[c]),
      .ovf      (ovf_all[c])
    );
  end

  // Only one channel can accept per cycle since a single wch selects it.
  always_comb begin
    mem_d = mem_q;
    for (int c = 0; c < NCH; c++) begin
      if (ch_accept[c]) begin
        mem_d[MIW'(c * DEPTH + int'(ch_waddr[c]))] = bus.wdata;
      end
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    bus.rdata = '0;
    if (int'(bus.rch) < NCH) begin
      bus.rdata = mem_q[MIW'(int'(bus.rch) * DEPTH + int'(bus.raddr))];
    end
  end

  assign bus.wptr_gray = gray_all;
  assign bus.wfull     = full_all;
  assign bus.wovf      = ovf_all;

endmodule

// File: tb/tb_fifo_mem_mch.sv
// Directed bench for fifo_mem_mch: a default 4-channel instance plus a 3-channel
// instance for out-of-range channel handling.
module tb_fifo_mem_mch;

  logic wclk;
  logic wrst_n;
  int   checks;
  int   failures;

  fifo_mem_mch_if #(.DATA(16), .DEPTH(8), .NCH(4)) if_a ();
  fifo_mem_mch_if #(.DATA(16), .DEPTH(8), .NCH(3)) if_b ();

  fifo_mem_mch #(.DATA(16), .DEPTH(8), .NCH(4)) u_dut_a (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (if_a)
  );

  fifo_mem_mch #(.DATA(16), .DEPTH(8), .NCH(3)) u_dut_b (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (if_b)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic write_a(input logic [1:0] ch, input logic [15:0] d);
    @(negedge wclk);
    if_a.winc  = 1'b1;
    if_a.wch   = ch;
    if_a.wdata = d;
    @(posedge wclk);
    #1;
    if_a.winc = 1'b0;
  endtask

  task automatic write_b(input logic [1:0] ch, input logic [15:0] d);
    @(negedge wclk);
    if_b.winc  = 1'b1;
    if_b.wch   = ch;
    if_b.wdata = d;
    @(posedge wclk);
    #1;
    if_b.winc = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge wclk);
    @(posedge wclk);
    #1;
  endtask

  task automatic test_reset();
    if_a.winc = 0; if_a.wch = 0; if_a.wdata = 0; if_a.wq2_rptr = 0;
    if_a.ovf_clr = 0; if_a.rch = 0; if_a.raddr = 0;
    if_b.winc = 0; if_b.wch = 0; if_b.wdata = 0; if_b.wq2_rptr = 0;
    if_b.ovf_clr = 0; if_b.rch = 0; if_b.raddr = 0;
    wrst_n = 1'b0;
    #12;
    checks++;
    if (if_a.wptr_gray !== 16'h0) begin
      failures++; $display("[TB] FAIL reset_gray got=%h exp=0000", if_a.wptr_gray);
    end
    checks++;
    if (if_a.wfull !== 4'h0 || if_a.wovf !== 4'h0) begin
      failures++; $display("[TB] FAIL reset_flags got full=%b ovf=%b exp=0", if_a.wfull, if_a.wovf);
    end
    for (int c = 0; c < 4; c++) begin
      for (int a = 0; a < 8; a++) begin
        if_a.rch = 2'(c); if_a.raddr = 3'(a);
        #1;
        checks++;
        if (if_a.rdata !== 16'h0) begin
          failures++; $display("[TB] FAIL reset_rdata ch%0d a%0d got=%h exp=0000", c, a, if_a.rdata);
        end
      end
    end
    @(negedge wclk);
    wrst_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 7; i++) write_a(2'd2, 16'hA000 + 16'(i));
    checks++;
    if (if_a.wfull !== 4'b0000) begin
      failures++; $display("[TB] FAIL fill_not_full_7 got=%b exp=0000", if_a.wfull);
    end
    write_a(2'd2, 16'hA007);
    checks++;
    if (if_a.wfull !== 4'b0100) begin
      failures++; $display("[TB] FAIL fill_full got=%b exp=0100", if_a.wfull);
    end
    checks++;
    if (if_a.wptr_gray !== 16'h0C00) begin
      failures++; $display("[TB] FAIL fill_gray got=%h exp=0c00", if_a.wptr_gray);
    end
    if_a.rch = 2'd2;
    for (int a = 0; a < 8; a++) begin
      if_a.raddr = 3'(a);
      #1;
      checks++;
      if (if_a.rdata !== 16'hA000 + 16'(a)) begin
        failures++; $display("[TB] FAIL fill_read a%0d got=%h exp=%h", a, if_a.rdata, 16'hA000 + 16'(a));
      end
    end
  endtask

  task automatic test_overflow();
    write_a(2'd2, 16'hBEEF);
    checks++;
    if (if_a.wovf !== 4'b0100) begin
      failures++; $display("[TB] FAIL ovf_set got=%b exp=0100", if_a.wovf);
    end
    if_a.rch = 2'd2; if_a.raddr = 3'd0;
    #1;
    checks++;
    if (if_a.rdata !== 16'hA000 || if_a.wptr_gray !== 16'h0C00) begin
      failures++; $display("[TB] FAIL ovf_drop got data=%h gray=%h exp a000/0c00", if_a.rdata, if_a.wptr_gray);
    end
    @(negedge wclk);
    if_a.ovf_clr = 4'b0100;
    @(posedge wclk);
    #1;
    if_a.ovf_clr = 4'b0000;
    checks++;
    if (if_a.wovf !== 4'b0000) begin
      failures++; $display("[TB] FAIL ovf_clear got=%b exp=0000", if_a.wovf);
    end
    @(negedge wclk);
    if_a.ovf_clr = 4'b0100;
    if_a.winc = 1'b1; if_a.wch = 2'd2; if_a.wdata = 16'hBAD0;
    @(posedge wclk);
    #1;
    if_a.ovf_clr = 4'b0000;
    if_a.winc = 1'b0;
    checks++;
    if (if_a.wovf !== 4'b0100) begin
      failures++; $display("[TB] FAIL ovf_set_wins got=%b exp=0100", if_a.wovf);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_mem [8];
    if_a.wq2_rptr[8 +: 4] = 4'b0010;
    idle_cycle();
    checks++;
    if (if_a.wfull !== 4'b0000) begin
      failures++; $display("[TB] FAIL rptr_unfull got=%b exp=0000", if_a.wfull);
    end
    for (int i = 0; i < 3; i++) write_a(2'd2, 16'hC000 + 16'(i));
    checks++;
    if (if_a.wfull !== 4'b0100 || if_a.wptr_gray[8 +: 4] !== 4'b1110) begin
      failures++; $display("[TB] FAIL refill got full=%b gray=%b exp 0100/1110", if_a.wfull, if_a.wptr_gray[8 +: 4]);
    end
    if_a.wq2_rptr[8 +: 4] = 4'b1110;
    idle_cycle();
    for (int i = 3; i < 8; i++) write_a(2'd2, 16'hD000 + 16'(i));
    checks++;
    if (if_a.wptr_gray[8 +: 4] !== 4'b0000 || if_a.wfull !== 4'b0000) begin
      failures++; $display("[TB] FAIL wrap_zero got gray=%b full=%b exp 0000/0000", if_a.wptr_gray[8 +: 4], if_a.wfull);
    end
    write_a(2'd2, 16'hD100);
    checks++;
    if (if_a.wptr_gray[8 +: 4] !== 4'b0001) begin
      failures++; $display("[TB] FAIL wrap_next got=%b exp=0001", if_a.wptr_gray[8 +: 4]);
    end
    exp_mem = '{16'hD100, 16'hC001, 16'hC002, 16'hD003, 16'hD004, 16'hD005, 16'hD006, 16'hD007};
    if_a.rch = 2'd2;
    for (int a = 0; a < 8; a++) begin
      if_a.raddr = 3'(a);
      #1;
      checks++;
      if (if_a.rdata !== exp_mem[a]) begin
        failures++; $display("[TB] FAIL wrap_read a%0d got=%h exp=%h", a, if_a.rdata, exp_mem[a]);
      end
    end
  endtask

  task automatic test_interleave();
    write_a(2'd0, 16'h1111);
    write_a(2'd3, 16'h3333);
    write_a(2'd0, 16'h1112);
    write_a(2'd3, 16'h3334);
    write_a(2'd0, 16'h1113);
    checks++;
    if (if_a.wptr_gray !== 16'h3102) begin
      failures++; $display("[TB] FAIL ilv_gray got=%h exp=3102", if_a.wptr_gray);
    end
    if_a.rch = 2'd0; if_a.raddr = 3'd2;
    #1;
    checks++;
    if (if_a.rdata !== 16'h1113) begin
      failures++; $display("[TB] FAIL ilv_ch0 got=%h exp=1113", if_a.rdata);
    end
    if_a.rch = 2'd3; if_a.raddr = 3'd1;
    #1;
    checks++;
    if (if_a.rdata !== 16'h3334) begin
      failures++; $display("[TB] FAIL ilv_ch3 got=%h exp=3334", if_a.rdata);
    end
    if_a.rch = 2'd1; if_a.raddr = 3'd0;
    #1;
    checks++;
    if (if_a.rdata !== 16'h0000) begin
      failures++; $display("[TB] FAIL ilv_ch1 got=%h exp=0000", if_a.rdata);
    end
    if_a.rch = 2'd2; if_a.raddr = 3'd0;
    #1;
    checks++;
    if (if_a.rdata !== 16'hD100) begin
      failures++; $display("[TB] FAIL ilv_ch2 got=%h exp=d100", if_a.rdata);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge wclk);
    if_a.winc = 1'b1; if_a.wch = 2'd1; if_a.wdata = 16'h5A5A;
    if_a.rch = 2'd1; if_a.raddr = 3'd0;
    #1;
    checks++;
    if (if_a.rdata !== 16'h0000) begin
      failures++; $display("[TB] FAIL rdw_old got=%h exp=0000", if_a.rdata);
    end
    @(negedge wclk);
    if_a.wdata = 16'h5A5B;
    @(posedge wclk);
    #1;
    if_a.winc = 1'b0;
    checks++;
    if (if_a.rdata !== 16'h5A5A) begin
      failures++; $display("[TB] FAIL rdw_new got=%h exp=5a5a", if_a.rdata);
    end
    if_a.raddr = 3'd1;
    #1;
    checks++;
    if (if_a.rdata !== 16'h5A5B || if_a.wptr_gray[4 +: 4] !== 4'b0011) begin
      failures++; $display("[TB] FAIL b2b got data=%h gray=%b exp 5a5b/0011", if_a.rdata, if_a.wptr_gray[4 +: 4]);
    end
  endtask

  task automatic test_nch3();
    write_b(2'd0, 16'h7777);
    write_b(2'd3, 16'hDEAD);
    checks++;
    if (if_b.wptr_gray !== 12'h001 || if_b.wfull !== 3'b000 || if_b.wovf !== 3'b000) begin
      failures++; $display("[TB] FAIL n3_ignore got gray=%h full=%b ovf=%b exp 001/000/000", if_b.wptr_gray, if_b.wfull, if_b.wovf);
    end
    if_b.rch = 2'd3; if_b.raddr = 3'd0;
    #1;
    checks++;
    if (if_b.rdata !== 16'h0000) begin
      failures++; $display("[TB] FAIL n3_rch3 got=%h exp=0000", if_b.rdata);
    end
    if_b.rch = 2'd0;
    #1;
    checks++;
    if (if_b.rdata !== 16'h7777) begin
      failures++; $display("[TB] FAIL n3_ch0 got=%h exp=7777", if_b.rdata);
    end
    if_b.raddr = 3'd1;
    #1;
    checks++;
    if (if_b.rdata !== 16'h0000) begin
      failures++; $display("[TB] FAIL n3_ch0a1 got=%h exp=0000", if_b.rdata);
    end
  endtask

  task automatic test_reset_midop();
    write_a(2'd1, 16'h6001);
    @(negedge wclk);
    #2;
    wrst_n = 1'b0;
    #1;
    checks++;
    if (if_a.wptr_gray !== 16'h0 || if_a.wfull !== 4'h0 || if_a.wovf !== 4'h0) begin
      failures++; $display("[TB] FAIL midrst_state got gray=%h full=%b ovf=%b exp 0", if_a.wptr_gray, if_a.wfull, if_a.wovf);
    end
    checks++;
    if (if_b.wptr_gray !== 12'h0) begin
      failures++; $display("[TB] FAIL midrst_n3 got=%h exp=000", if_b.wptr_gray);
    end
    for (int c = 0; c < 4; c++) begin
      for (int a = 0; a < 8; a++) begin
        if_a.rch = 2'(c); if_a.raddr = 3'(a);
        #1;
        checks++;
        if (if_a.rdata !== 16'h0) begin
          failures++; $display("[TB] FAIL midrst_rdata ch%0d a%0d got=%h exp=0000", c, a, if_a.rdata);
        end
      end
    end
    if_a.wq2_rptr = '0;
    @(negedge wclk);
    wrst_n = 1'b1;
    write_a(2'd0, 16'h4242);
    if_a.rch = 2'd0; if_a.raddr = 3'd0;
    #1;
    checks++;
    if (if_a.rdata !== 16'h4242 || if_a.wptr_gray !== 16'h0001) begin
      failures++; $display("[TB] FAIL post_rst_write got data=%h gray=%h exp 4242/0001", if_a.rdata, if_a.wptr_gray);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_fill();
    test_overflow();
    test_wrap();
    test_interleave();
    test_back_to_back();
    test_nch3();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_mem_mch.md
# fifo_mem_mch

Multi-channel successor to the async-FIFO storage block. Holds NCH independent logical FIFOs of DEPTH words each in one register array. Owns the write-domain side of every channel: binary/Gray write pointer, registered full flag and sticky overflow flag. Read-domain logic (read pointers, empty, synchronisers) stays outside; reads are combinational by channel plus address.

## Interface
Parameters:
- DATA, 16: word width in bits.
- DEPTH, 8: words per channel; power of two, ≥2. AW = log2(DEPTH).
- NCH, 4: channel count, ≥2. CW = ceil(log2(NCH)).

Ports:
- wclk  in  1  write clock; all state updates on its rising edge.
- wrst_n  in  1  asynchronous, active-low reset.
- winc  in  1  write request.
- wch  in  CW  target channel of the write.
- wdata  in  DATA  write word.
- wq2_rptr  in  NCH*(AW+1)  per-channel Gray read pointers, already synchronised into wclk; channel c occupies bits [c*(AW+1) +: AW+1].
- ovf_clr  in  NCH  per-channel overflow clear, one bit per channel.
- rch  in  CW  read channel select.
- raddr  in  AW  read word address within rch.
- rdata  out  DATA  combinational read of word raddr of channel rch.
- wptr_gray  out  NCH*(AW+1)  per-channel Gray write pointers, registered; same packing as wq2_rptr.
- wfull  out  NCH  per-channel full flag, registered.
- wovf  out  NCH  per-channel sticky overflow flag.

## Operation
- Storage: NCH*DEPTH words; physical index = wch*DEPTH + waddr, where waddr = low AW bits of that channel's binary pointer.
- Write accepted iff winc=1, wch<NCH, and wfull[wch]=0. On acceptance, the word is stored and that channel's binary pointer is incremented, modulo 2*DEPTH. The Gray pointer is updated on the same edge.
- Write ignored, with no state change at all, when wch≥NCH.
- Write to a full channel: data dropped, pointer unchanged, wovf[wch] set.
- Full: on every edge, wfull[c] is loaded with (gray_next_c == {~wq2_rptr_c[AW:AW-1], wq2_rptr_c[AW-2:0]}).
  - gray_next_c is the Gray code of the channel's next binary pointer, which includes this cycle's accepted write, if any.
  - For DEPTH=2 (AW=1), the compare term is ~wq2_rptr_c[1:0].
- Overflow clear: ovf_clr[c]=1 clears wovf[c]. If a set and a clear hit the same channel in the same cycle, the set wins.
- Channels are fully independent; at most one write per cycle.
- rdata = mem[rch*DEPTH + raddr]. If rch≥NCH, rdata = 0.
- Reset, asynchronous, mid-operation included: all pointers 0, wptr_gray 0, wfull 0, wovf 0, all memory words 0, therefore rdata 0.

## Timing
- Write latency: a word accepted at edge N is visible on rdata after edge N, combinationally, with no read-clock dependency.
- wptr_gray and wfull change only on wclk edges. A wq2_rptr change is reflected in wfull at the next edge.
- Pointer wrap: binary pointer goes 2*DEPTH-1 → 0; Gray pointer goes from {1,0…0} to 0. No glitch, because outputs are registered.
- Read of an address being written in the same cycle returns old data until the edge.
- Reset deassertion is synchronised outside; first write is accepted on the first edge after release.

## Structure
- Package fifo_mem_pkg:
  - bin2gray function.
  - Width helpers: AW and CW derivation.
  - Packed-slice index helper for per-channel pointer buses.
- Sub-module fifo_wptr_full: one channel's binary/Gray pointer, full flag and overflow flag. Instantiated NCH times in a generate loop; the top holds the memory array and the write/read muxing.

## Test plan
Default configuration is DATA=16, DEPTH=8, NCH=4 unless stated.
- Reset → wfull=0, wovf=0, wptr_gray=0; rdata=0 for every rch/raddr.
- Eight writes 0xA000..0xA007 to ch2 with wq2_rptr=0 → wfull[2]=1 after the 8th edge; ch2 Gray pointer = 4'b1100; other channels stay 0; ch2 raddr 0..7 reads back 0xA000..0xA007.
- 9th write 0xBEEF to full ch2 → ch2 memory unchanged, wovf[2]=1. Pulse ovf_clr[2] → wovf[2]=0. Set and clear in the same cycle → wovf[2]=1.
- Set ch2 wq2_rptr to Gray(3)=4'b0010 → wfull[2]=0 next edge. Three writes → wfull[2]=1 again; the pointer then wraps 15→0 on further read/write cycling with data intact.
- Interleaved writes to ch0 and ch3 (0x1111, 0x3333, …) → each channel's pointer advances only on its own writes; no cross-channel corruption.
- With NCH=3: wch=3 write ignored with no state change, and rch=3 reads 0. Separately, assert wrst_n low after a partial fill → all outputs, pointers and memory return to 0 immediately.
